entrada_serial_medida: RTL

- Receiving end of the serial measurement link. It deserializes the asynchronous character stream sent by the measurement transmitter.
- Frame format: 3 ASCII angle digits, ',', 3 ASCII distance digits, '#'.
- Parses and validates the frame, then presents the angle as ASCII (24 bits) and the distance as BCD (12 bits), strobed by a one-cycle pronto.
- Sits on the host/monitor side of the link, ahead of display or checking logic.

---
 rtl/entrada_serial_medida.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/entrada_serial_medida.sv
// Serial measurement-link receiver: 8N1 (or 7E1 with RX_PARIDADE_EN) bytes parsed as "AAA,DDD#".
// Latency: pronto 2 clocks after the '#' stop-bit sample; no backpressure, every frame is published or flagged.
module entrada_serial_medida #(
    parameter int CICLOS_POR_BIT  = 434,
    parameter int CICLOS_MEIO_BIT = CICLOS_POR_BIT / 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [23:0] angulos,
    output logic [11:0] dados,
    output logic        pronto,
    output logic        erro,
    output logic        db_entrada_serial,
    output logic [3:0]  db_estado
);
    localparam int CW = $clog2(CICLOS_POR_BIT + 1);
    localparam logic [CW-1:0] ULTIMO_TICK = CW'(CICLOS_POR_BIT - 1);
    localparam logic [CW-1:0] MEIO_TICK   = CW'(CICLOS_MEIO_BIT - 1);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} rx_t;
    typedef enum logic [3:0] {
        AG0 = 4'd0, AG1 = 4'd1, AG2 = 4'd2, VIRG = 4'd3, DS0 = 4'd4,
        DS1 = 4'd5, DS2 = 4'd6, FIM = 4'd7, PUBLICA = 4'd8
    } est_t;

    logic          s1_q, s2_q;
    rx_t           rx_q, rx_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [2:0]    nbit_q, nbit_d;
    logic [7:0]    sr_q, sr_d;
    logic          espera_q, espera_d;
    logic          byte_ok_q, byte_ok_d;
    logic          ferr_q, ferr_d;
    logic          par_ok;
    logic [7:0]    dado;

    est_t          est_q, est_d;
    logic [23:0]   ang_sh_q, ang_sh_d, angulos_q, angulos_d;
    logic [11:0]   dist_sh_q, dist_sh_d, dados_q, dados_d;
    logic          pronto_q, pronto_d, erro_q, erro_d;
    logic          digito, aceito;

    // In 7E1 the shift register's top bit is the parity bit; the character is zero-extended.
`ifdef RX_PARIDADE_EN
    assign par_ok = ~^sr_q;
    assign dado   = {1'b0, sr_q[6:0]};
`else
    assign par_ok = 1'b1;
    assign dado   = sr_q;
`endif

    always_comb begin
        rx_d      = rx_q;
        cont_d    = cont_q;
        nbit_d    = nbit_q;
        sr_d      = sr_q;
        espera_d  = espera_q;
        byte_ok_d = 1'b0;
        ferr_d    = 1'b0;
        case (rx_q)
            OCIOSO: begin
                if (espera_q) begin
                    if (s2_q) espera_d = 1'b0;
                end else if (!s2_q) begin
                    rx_d   = INICIO;
                    cont_d = '0;
                end
            end
            INICIO: begin
                if (cont_q == MEIO_TICK) begin
                    cont_d = '0;
                    nbit_d = 3'd0;
                    rx_d   = s2_q ? OCIOSO : DADOS;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            DADOS: begin
                if (cont_q == ULTIMO_TICK) begin
                    cont_d = '0;
                    sr_d   = {s2_q, sr_q[7:1]};
                    nbit_d = nbit_q + 3'd1;
                    if (nbit_q == 3'd7) rx_d = PARADA;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            PARADA: begin
                if (cont_q == ULTIMO_TICK) begin
                    cont_d = '0;
                    rx_d   = OCIOSO;
                    if (s2_q && par_ok) begin
                        byte_ok_d = 1'b1;
                    end else begin
                        ferr_d   = 1'b1;
                        // A low stop bit means we are mid-break: ignore the line until it idles.
                        espera_d = !s2_q;
                    end
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            default: rx_d = OCIOSO;
        endcase
    end

    assign digito = (dado >= 8'h30) && (dado <= 8'h39);

    always_comb begin
        est_d     = est_q;
        ang_sh_d  = ang_sh_q;
        dist_sh_d = dist_sh_q;
        angulos_d = angulos_q;
        dados_d   = dados_q;
        pronto_d  = 1'b0;
        erro_d    = 1'b0;
        aceito    = 1'b0;
        if (est_q == PUBLICA) begin
            angulos_d = ang_sh_q;
            dados_d   = dist_sh_q;
            pronto_d  = 1'b1;
            est_d     = AG0;
        end else if (ferr_q) begin
            erro_d = 1'b1;
            est_d  = AG0;
        end else if (byte_ok_q) begin
            case (est_q)
                AG0:  if (digito) begin aceito = 1'b1; ang_sh_d[23:16] = dado; est_d = AG1; end
                AG1:  if (digito) begin aceito = 1'b1; ang_sh_d[15:8]  = dado; est_d = AG2; end
                AG2:  if (digito) begin aceito = 1'b1; ang_sh_d[7:0]   = dado; est_d = VIRG; end
                VIRG: if (dado == 8'h2C) begin aceito = 1'b1; est_d = DS0; end
                DS0:  if (digito) begin aceito = 1'b1; dist_sh_d[11:8] = dado[3:0]; est_d = DS1; end
                DS1:  if (digito) begin aceito = 1'b1; dist_sh_d[7:4]  = dado[3:0]; est_d = DS2; end
                DS2:  if (digito) begin aceito = 1'b1; dist_sh_d[3:0]  = dado[3:0]; est_d = FIM; end
                FIM:  if (dado == 8'h23) begin aceito = 1'b1; est_d = PUBLICA; end
                default: aceito = 1'b0;
            endcase
            // Stale shadow fields are harmless: every field is rewritten before the next PUBLICA.
            if (!aceito) begin
                erro_d = 1'b1;
                est_d  = AG0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            rx_q      <= OCIOSO;
            cont_q    <= '0;
            nbit_q    <= 3'd0;
            sr_q      <= 8'h00;
            espera_q  <= 1'b0;
            byte_ok_q <= 1'b0;
            ferr_q    <= 1'b0;
            est_q     <= AG0;
            ang_sh_q  <= 24'h0;
            dist_sh_q <= 12'h0;
            angulos_q <= 24'h0;
            dados_q   <= 12'h0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            s1_q      <= entrada_serial;
            s2_q      <= s1_q;
            rx_q      <= rx_d;
            cont_q    <= cont_d;
            nbit_q    <= nbit_d;
            sr_q      <= sr_d;
            espera_q  <= espera_d;
            byte_ok_q <= byte_ok_d;
            ferr_q    <= ferr_d;
            est_q     <= est_d;
            ang_sh_q  <= ang_sh_d;
            dist_sh_q <= dist_sh_d;
            angulos_q <= angulos_d;
            dados_q   <= dados_d;
            pronto_q  <= pronto_d;
            erro_q    <= erro_d;
        end
    end

    assign angulos           = angulos_q;
    assign dados             = dados_q;
    assign pronto            = pronto_q;
    assign erro              = erro_q;
    assign db_entrada_serial = s2_q;
    assign db_estado         = est_q;
endmodule
